// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
//   Shared definitions for the multi-cycle control unit: opcode constants,
//   FSM state encodings, RF write-data select encodings and the packed
//   control word that the decoder produces and the FSM registers.
package riscv_ctrl_pkg;

  // Opcodes, taken from IR[6:0]
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // FSM state encodings
  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // RF write-data select
  localparam logic [1:0] RF_DIN_DM    = 2'b00;
  localparam logic [1:0] RF_DIN_ULA   = 2'b01;
  localparam logic [1:0] RF_DIN_PC4   = 2'b10;
  localparam logic [1:0] RF_DIN_PCIMM = 2'b11;

  typedef struct packed {
    logic       we_rf;
    logic       we_mem;
    logic [1:0] rf_din_sel;
    logic       ula_din2_sel;
    logic       load_pc;
    logic       pc_next_sel;
    logic       pc_adder_sel;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NONE = '0;

  // Write-back phase of a load: DM data into the RF and advance the PC.
  localparam ctrl_word_t CW_LOAD_MEM = '{
    we_rf: 1'b1, we_mem: 1'b0, rf_din_sel: RF_DIN_DM, ula_din2_sel: 1'b1,
    load_pc: 1'b1, pc_next_sel: 1'b0, pc_adder_sel: 1'b0
  };

endpackage

// File: rtl/control_decoder.sv
// control_decoder
//   Combinational opcode decode into the EXEC-phase control word.
//   Ports:
//     i_opcode     in  7  IR[6:0]
//     o_cw         out    EXEC control word (all zero for SYSTEM/illegal)
//     o_is_load    out 1  LOAD opcode, needs the MEM phase
//     o_is_system  out 1  SYSTEM opcode (ECALL/EBREAK), halts cleanly
//     o_is_illegal out 1  opcode not in the supported set
module control_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output ctrl_word_t o_cw,
  output logic       o_is_load,
  output logic       o_is_system,
  output logic       o_is_illegal
);

  always_comb begin
    o_cw         = CW_NONE;
    o_is_load    = 1'b0;
    o_is_system  = 1'b0;
    o_is_illegal = 1'b0;
    case (i_opcode)
      OPC_OP, OPC_OP_32: begin
        o_cw.we_rf      = 1'b1;
        o_cw.rf_din_sel = RF_DIN_ULA;
        o_cw.load_pc    = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LUI: begin
        o_cw.we_rf        = 1'b1;
        o_cw.rf_din_sel   = RF_DIN_ULA;
        o_cw.ula_din2_sel = 1'b1;
        o_cw.load_pc      = 1'b1;
      end
      OPC_AUIPC: begin
        o_cw.we_rf      = 1'b1;
        o_cw.rf_din_sel = RF_DIN_PCIMM;
        o_cw.load_pc    = 1'b1;
      end
      OPC_LOAD: begin
        // Address calc only; write-back and PC update happen in MEM.
        o_cw.ula_din2_sel = 1'b1;
        o_is_load         = 1'b1;
      end
      OPC_STORE: begin
        o_cw.we_mem       = 1'b1;
        o_cw.ula_din2_sel = 1'b1;
        o_cw.load_pc      = 1'b1;
      end
      OPC_BRANCH: begin
        o_cw.load_pc     = 1'b1;
        o_cw.pc_next_sel = 1'b1;
      end
      OPC_JAL: begin
        o_cw.we_rf       = 1'b1;
        o_cw.rf_din_sel  = RF_DIN_PC4;
        o_cw.load_pc     = 1'b1;
        o_cw.pc_next_sel = 1'b1;
      end
      OPC_JALR: begin
        o_cw.we_rf        = 1'b1;
        o_cw.rf_din_sel   = RF_DIN_PC4;
        o_cw.load_pc      = 1'b1;
        o_cw.pc_next_sel  = 1'b1;
        o_cw.pc_adder_sel = 1'b1;
      end
      OPC_SYSTEM: o_is_system  = 1'b1;
      default:    o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Multi-cycle control FSM driving the datapath control inputs. Every
//   output is a register loaded from the next-state decode, so each state's
//   controls are valid for the whole cycle the FSM spends in it.
//   Optional feature macro: CTRL_PERF_COUNTERS_EN (cycle/instret counters;
//   when undefined both counter ports are tied to zero).
//   Ports:
//     CLK, RST_N            clock (rising edge), async active-low reset
//     RUN                   run enable, sampled in FETCH
//     opcode[6:0]           IR[6:0] from the datapath
//     WE_RF, WE_MEM         RF / DM write strobes
//     RF_din_sel[1:0]       RF write-data select
//     ULA_din2_sel          ALU operand 2: rs2 / immediate
//     load_pc, reset_pc     PC update / reset
//     pc_next_sel           PC+4 / secondary adder
//     pc_adder_sel          secondary adder base: PC / rs1
//     reset_ir              IR reset
//     halted, illegal       halt status, halt caused by illegal opcode
//     cycle_count[63:0]     cycles outside RESET/HALT
//     instret_count[63:0]   retired instructions
//
//   state  | meaning
//   RESET  | PC and IR held in reset, one cycle after reset release
//   FETCH  | IR loads on exit; waits here while RUN=0
//   DECODE | opcode valid, control word captured
//   EXEC   | execute; non-loads write RF/DM and update PC on exit
//   MEM    | load write-back and PC update
//   HALT   | absorbing until reset
module control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RUN,
  input  logic [6:0]  opcode,
  output logic        WE_RF,
  output logic        WE_MEM,
  output logic [1:0]  RF_din_sel,
  output logic        ULA_din2_sel,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        pc_next_sel,
  output logic        pc_adder_sel,
  output logic        reset_ir,
  output logic        halted,
  output logic        illegal,
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count
);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  ctrl_word_t r_cw;
  ctrl_word_t w_cw_nxt;
  logic       r_is_load;
  logic       r_reset_pc;
  logic       r_reset_ir;
  logic       r_halted;
  logic       r_illegal;
  logic       w_illegal_nxt;

  ctrl_word_t w_dec_cw;
  logic       w_dec_is_load;
  logic       w_dec_is_system;
  logic       w_dec_is_illegal;

  control_decoder u_decoder (
    .i_opcode     (opcode),
    .o_cw         (w_dec_cw),
    .o_is_load    (w_dec_is_load),
    .o_is_system  (w_dec_is_system),
    .o_is_illegal (w_dec_is_illegal)
  );

  always_comb begin
    w_state_nxt = ST_RESET;
    case (r_state)
      ST_RESET:  w_state_nxt = ST_FETCH;
      ST_FETCH:  w_state_nxt = RUN ? ST_DECODE : ST_FETCH;
      ST_DECODE: w_state_nxt = (w_dec_is_system || w_dec_is_illegal) ? ST_HALT : ST_EXEC;
      ST_EXEC:   w_state_nxt = r_is_load ? ST_MEM : ST_FETCH;
      ST_MEM:    w_state_nxt = ST_FETCH;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_RESET;
    endcase
  end

  // EXEC is only entered from DECODE, so the live decoder output is the
  // control word to register; the strobes are zero in every other state.
  always_comb begin
    w_cw_nxt = CW_NONE;
    case (w_state_nxt)
      ST_EXEC: w_cw_nxt = w_dec_cw;
      ST_MEM:  w_cw_nxt = CW_LOAD_MEM;
      default: w_cw_nxt = CW_NONE;
    endcase
  end

  always_comb begin
    w_illegal_nxt = 1'b0;
    if (r_state == ST_HALT)
      w_illegal_nxt = r_illegal;
    else if (r_state == ST_DECODE && w_state_nxt == ST_HALT)
      w_illegal_nxt = w_dec_is_illegal;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_RESET;
      r_cw       <= CW_NONE;
      r_is_load  <= 1'b0;
      r_reset_pc <= 1'b1;
      r_reset_ir <= 1'b1;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cw       <= w_cw_nxt;
      r_reset_pc <= (w_state_nxt == ST_RESET);
      r_reset_ir <= (w_state_nxt == ST_RESET);
      r_halted   <= (w_state_nxt == ST_HALT);
      r_illegal  <= w_illegal_nxt;
      if (r_state == ST_DECODE)
        r_is_load <= w_dec_is_load;
    end
  end

  assign WE_RF        = r_cw.we_rf;
  assign WE_MEM       = r_cw.we_mem;
  assign RF_din_sel   = r_cw.rf_din_sel;
  assign ULA_din2_sel = r_cw.ula_din2_sel;
  assign load_pc      = r_cw.load_pc;
  assign pc_next_sel  = r_cw.pc_next_sel;
  assign pc_adder_sel = r_cw.pc_adder_sel;
  assign reset_pc     = r_reset_pc;
  assign reset_ir     = r_reset_ir;
  assign halted       = r_halted;
  assign illegal      = r_illegal;

`ifdef CTRL_PERF_COUNTERS_EN
  logic [63:0] r_cycle_count;
  logic [63:0] r_instret_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cycle_count   <= 64'd0;
      r_instret_count <= 64'd0;
    end else begin
      if (r_state != ST_RESET && r_state != ST_HALT)
        r_cycle_count <= r_cycle_count + 64'd1;
      if ((r_state == ST_EXEC || r_state == ST_MEM) && w_state_nxt == ST_FETCH)
        r_instret_count <= r_instret_count + 64'd1;
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;
`else
  assign cycle_count   = 64'd0;
  assign instret_count = 64'd0;
`endif

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM sitting directly upstream of `datapath`: it reads the opcode held in the instruction register and drives every datapath control input (register-file/memory write enables, mux selects, PC load/reset, IR reset). It sequences each instruction through FETCH → DECODE → EXEC (loads add MEM) and halts on ECALL/EBREAK or illegal opcodes.

## Interface
- No parameters.
- `CLK` in 1: system clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `RUN` in 1: run enable; sampled only in FETCH.
- `opcode` in 7: IR bits [6:0], exported by `datapath`.
- `WE_RF` out 1: register-file write strobe.
- `WE_MEM` out 1: data-memory write strobe.
- `RF_din_sel` out 2: RF write-data select: 00 DM_out, 01 ula, 10 PC+4 (primary adder), 11 PC+imm (secondary adder).
- `ULA_din2_sel` out 1: 0 rs2, 1 immediate.
- `load_pc` out 1: PC update strobe.
- `reset_pc` out 1: PC reset.
- `pc_next_sel` out 1: 0 PC+4; 1 secondary adder (the PC evaluates the branch condition internally).
- `pc_adder_sel` out 1: secondary adder base: 0 PC, 1 rs1 (JALR).
- `reset_ir` out 1: IR reset.
- `halted` out 1: FSM is in HALT.
- `illegal` out 1: halt was caused by an illegal opcode.
- `cycle_count` out 64: cycles since reset (see Configuration).
- `instret_count` out 64: instructions retired (see Configuration).

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, HALT. Encodings are defined in the package.
- **RESET**: `reset_pc`=1, `reset_ir`=1, all strobes 0. Always goes to FETCH next cycle.
- **FETCH**: all strobes 0. If `RUN`=1, go to DECODE; otherwise stay in FETCH.
- **DECODE**: the `control_decoder` output is registered into a control word. Next state is HALT for SYSTEM (1110011) and for any unlisted opcode; otherwise EXEC.
- **EXEC**: drive the registered selects; assert strobes per opcode. Next state is MEM for LOAD, otherwise FETCH.
- **MEM** (loads only): `WE_RF`=1, `RF_din_sel`=00, `ULA_din2_sel`=1, `load_pc`=1, then go to FETCH.
- **HALT**: absorbing until reset. All strobes 0; `halted`=1.
- `illegal`=1 only if HALT was entered from an unlisted opcode; it stays 0 for SYSTEM.
- EXEC control word per opcode (fields not listed are 0; `load_pc`=1 for every opcode except LOAD, whose PC update is in MEM):
  - OP 0110011 and OP-32 0111011: WE_RF, RF_din=01, din2=0.
  - OP-IMM 0010011 and OP-IMM-32 0011011: WE_RF, RF_din=01, din2=1.
  - LUI 0110111: WE_RF, RF_din=01, din2=1.
  - AUIPC 0010111: WE_RF, RF_din=11.
  - LOAD 0000011: din2=1, no strobes in EXEC.
  - STORE 0100011: WE_MEM, din2=1.
  - BRANCH 1100011: din2=0, pc_next_sel=1.
  - JAL 1101111: WE_RF, RF_din=10, pc_next_sel=1.
  - JALR 1100111: WE_RF, RF_din=10, pc_next_sel=1, pc_adder_sel=1.
- `WE_RF`, `WE_MEM` and `load_pc` are never asserted outside EXEC/MEM. `WE_RF` and `WE_MEM` are never asserted together.

## Timing
- All outputs are registered (Moore).
- Async reset values: state=RESET, `reset_pc`=1, `reset_ir`=1, all other outputs 0, counters 0.
- The IR captures the new instruction on the FETCH→DECODE edge. Opcode is valid throughout DECODE.
- CPI: 3 for non-load instructions, 4 for loads.
- The PC and RF/DM write at the edge ending EXEC (or MEM for loads).
- Dropping `RUN` mid-instruction does not abort; the FSM stalls at the next FETCH.
- Asserting `RST_N` low mid-instruction forces RESET immediately. Strobes drop asynchronously; no partial write may follow.

## Configuration
- `CTRL_PERF_COUNTERS_EN` defined:
  - `cycle_count` increments every cycle outside RESET and HALT.
  - `instret_count` increments on each EXEC→FETCH or MEM→FETCH transition.
  - Both are 64-bit and wrap to 0.
- `CTRL_PERF_COUNTERS_EN` undefined: no counter registers; both ports are tied to 0.

## Structure
- Package `riscv_ctrl_pkg`: opcode constants, state encoding, `RF_din_sel` encodings, control-word struct.
- Sub-module `control_decoder`: combinational opcode → {control word, is_load, is_system, is_illegal}.

## Test plan
- Reset release with `RUN`=1 → one RESET cycle (`reset_pc`=`reset_ir`=1), then FETCH, with `halted`=0 throughout.
- ADD (0110011) → DECODE, then EXEC with `WE_RF`=1, `RF_din_sel`=01, `ULA_din2_sel`=0, `load_pc`=1; back in FETCH on cycle 4.
- LW (0000011) → EXEC with no strobes, then MEM with `WE_RF`=1, `RF_din_sel`=00, `load_pc`=1; instret +1 after 4 cycles.
- JALR (1100111) → EXEC with `RF_din_sel`=10, `pc_next_sel`=1, `pc_adder_sel`=1. SW (0100011) → `WE_MEM`=1, `WE_RF`=0.
- Opcode 1111111 → HALT with `illegal`=1. ECALL (1110011) → HALT with `illegal`=0. In both cases no strobes for 100 cycles.
- `RST_N` pulsed low during EXEC of a store → `WE_MEM` falls asynchronously and the FSM restarts at RESET. With `RUN`=0 in FETCH, the FSM holds and `cycle_count` still increments.
